// File: rtl/mips_mem_arbiter.sv
// Shared single-port memory arbiter for a MIPS core: one instruction-fetch
// port and one data port share a synchronous-read memory. Data accesses win
// by default; a run limit keeps a pending fetch from being starved. Halt
// masks fetch requests only.
module mips_mem_arbiter #(
   parameter int AW         = 10,
   parameter int MAX_DM_RUN = 2
) (
   input  logic          clk1,
   input  logic          rst_n,
   input  logic          halted,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [31:0]   if_rdata,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [31:0]   dm_wdata,
   output logic          dm_gnt,
   output logic          dm_rvalid,
   output logic [31:0]   dm_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata
);

   localparam int RUN_W = (MAX_DM_RUN < 1) ? 1 : $clog2(MAX_DM_RUN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DM_RUN);

   typedef enum logic [1:0] {IDLE, IF_ACC, DM_RD, DM_WR} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [RUN_W-1:0] dm_run;
   logic [RUN_W-1:0] dm_run_nxt;
   logic             armed;
   logic [AW-1:0]    addr_nxt;
   logic [31:0]      wdata_nxt;
   logic             if_pend;
   logic             take_if;

   // A halted core cannot fetch; the fetch wins only once the data run
   // has reached its limit (or when there is no data request at all).
   assign if_pend = if_req & ~halted;
   assign take_if = if_pend & (~dm_req | (dm_run == RUN_MAX));

   // State, run counter, registered memory command and read-valid tracking.
   // armed delays the first grant so the first edge after release only arms.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         dm_run    <= '0;
         armed     <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rvalid <= 1'b0;
         dm_rvalid <= 1'b0;
      end else begin
         armed     <= 1'b1;
         state     <= state_nxt;
         dm_run    <= dm_run_nxt;
         mem_addr  <= addr_nxt;
         mem_wdata <= wdata_nxt;
         if_rvalid <= (state == IF_ACC);
         dm_rvalid <= (state == DM_RD);
      end
   end

   // Arbitrate the sampled requests into the access issued next cycle.
   always_comb begin
      state_nxt  = IDLE;
      addr_nxt   = '0;
      wdata_nxt  = '0;
      dm_run_nxt = dm_run;
      if (armed) begin
         if (dm_req && !take_if) begin
            state_nxt = dm_we ? DM_WR : DM_RD;
            addr_nxt  = dm_addr;
            wdata_nxt = dm_wdata;
            if (if_pend && (dm_run != RUN_MAX)) begin
               dm_run_nxt = dm_run + RUN_W'(1);
            end
         end else if (if_pend) begin
            state_nxt = IF_ACC;
            addr_nxt  = if_addr;
         end
         if (!if_pend || (state_nxt == IF_ACC)) begin
            dm_run_nxt = '0;
         end
      end
   end

   // Decode grant/command strobes from the current access; gate read data.
   always_comb begin
      if_gnt   = (state == IF_ACC);
      dm_gnt   = (state == DM_RD) || (state == DM_WR);
      mem_en   = (state != IDLE);
      mem_we   = (state == DM_WR);
      if_rdata = if_rvalid ? mem_rdata : 32'd0;
      dm_rdata = dm_rvalid ? mem_rdata : 32'd0;
   end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Scoreboard bench for mips_mem_arbiter: directed sequences push expected
// grants and read returns; a negedge monitor pops and compares them.
module tb_mips_mem_arbiter;

   localparam int AW = 10;

   logic          clk1 = 1'b0;
   logic          rst_n;
   logic          halted = 1'b0;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_gnt, if_rvalid;
   logic [31:0]   if_rdata;
   logic          dm_req = 1'b0;
   logic          dm_we = 1'b0;
   logic [AW-1:0] dm_addr = '0;
   logic [31:0]   dm_wdata = '0;
   logic          dm_gnt, dm_rvalid;
   logic [31:0]   dm_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata = '0;

   typedef struct {
      logic [2:0]  kind;
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t exp_g[$];
   exp_t exp_r[$];
   int   n_checks = 0;
   int   n_fails  = 0;
   int   overlap_cnt = 0;

   localparam logic [2:0] K_IF   = 3'b100;
   localparam logic [2:0] K_DMRD = 3'b010;
   localparam logic [2:0] K_DMWR = 3'b011;

   mips_mem_arbiter #(.AW(AW), .MAX_DM_RUN(2)) dut (
      .clk1(clk1), .rst_n(rst_n), .halted(halted),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk1 = ~clk1;

   // Synchronous-read memory model: a read of word a returns a+100.
   always @(posedge clk1) begin
      if (mem_en && !mem_we) mem_rdata <= {22'd0, mem_addr} + 32'd100;
      else                   mem_rdata <= 32'hDEAD_BEEF;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
      end
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_if_gnt"},    32'(if_gnt),    0);
      chk({nm, "_if_rvalid"}, 32'(if_rvalid), 0);
      chk({nm, "_if_rdata"},  if_rdata,       0);
      chk({nm, "_dm_gnt"},    32'(dm_gnt),    0);
      chk({nm, "_dm_rvalid"}, 32'(dm_rvalid), 0);
      chk({nm, "_dm_rdata"},  dm_rdata,       0);
      chk({nm, "_mem_en"},    32'(mem_en),    0);
      chk({nm, "_mem_we"},    32'(mem_we),    0);
      chk({nm, "_mem_addr"},  32'(mem_addr),  0);
      chk({nm, "_mem_wdata"}, mem_wdata,      0);
   endtask

   task automatic push_g(input logic [2:0] k, input int a, input logic [31:0] d);
      exp_t e;
      e.kind = k; e.addr = 32'(a); e.data = d;
      exp_g.push_back(e);
   endtask

   task automatic push_r(input logic [2:0] k, input logic [31:0] d);
      exp_t e;
      e.kind = k; e.addr = 0; e.data = d;
      exp_r.push_back(e);
   endtask

   // Monitor: compare every presented grant and read return against the queues.
   always @(negedge clk1) begin
      if (rst_n === 1'b1) begin
         exp_t e;
         chk("gnt_exclusive",    32'(if_gnt & dm_gnt),       0);
         chk("rvalid_exclusive", 32'(if_rvalid & dm_rvalid), 0);
         if (!if_rvalid) chk("if_rdata_idle_zero", if_rdata, 0);
         if (!dm_rvalid) chk("dm_rdata_idle_zero", dm_rdata, 0);
         if (!if_gnt && !dm_gnt) begin
            chk("idle_mem_en", 32'(mem_en), 0);
            chk("idle_mem_we", 32'(mem_we), 0);
         end
         if (dm_rvalid && if_gnt) overlap_cnt++;
         if (if_gnt || dm_gnt) begin
            if (exp_g.size() == 0) begin
               chk("unexpected_grant", {29'd0, if_gnt, dm_gnt, mem_we}, 0);
            end else begin
               e = exp_g.pop_front();
               chk("grant_kind", {29'd0, if_gnt, dm_gnt, mem_we}, {29'd0, e.kind});
               chk("grant_mem_en", 32'(mem_en), 1);
               chk("grant_mem_addr", 32'(mem_addr), e.addr);
               chk("grant_mem_wdata", mem_wdata, e.data);
            end
         end
         if (if_rvalid || dm_rvalid) begin
            if (exp_r.size() == 0) begin
               chk("unexpected_rvalid", {29'd0, if_rvalid, dm_rvalid, 1'b0}, 0);
            end else begin
               e = exp_r.pop_front();
               chk("rvalid_source", {29'd0, if_rvalid, dm_rvalid, 1'b0}, {29'd0, e.kind});
               chk("rdata", if_rvalid ? if_rdata : dm_rdata, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, first, cyc, g, dg, ifg;
      bit hit;

      // Reset state and first-grant latency after release.
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1 chk_zero("reset");
      if_req = 1'b1; if_addr = '0;
      for (int i = 0; i < 9; i++) begin
         push_g(K_IF, i, 0);
         push_r(K_IF, 32'(i + 100));
      end
      repeat (2) @(posedge clk1);
      @(negedge clk1) rst_n = 1'b1;
      @(posedge clk1); #1;
      chk("first_edge_no_grant", 32'(if_gnt), 0);

      // Fetch-only burst, addresses 0..8 back to back.
      k = 0; first = -1; cyc = 0;
      while (k < 9 && cyc < 40) begin
         @(posedge clk1); #1; cyc++;
         if (if_gnt) begin
            if (k == 0) first = cyc;
            k++;
            if (k < 9) if_addr = AW'(k);
            else       if_req = 1'b0;
         end
      end
      chk("fetch_grant_count", 32'(k), 9);
      chk("fetch_first_latency", 32'(first), 1);
      chk("fetch_consecutive", 32'(cyc - first + 1), 9);
      repeat (3) @(posedge clk1);

      // Contention: LW at 20 against fetches starting at 50.
      push_g(K_DMRD, 20, 0); push_r(K_DMRD, 120);
      push_g(K_DMRD, 20, 0); push_r(K_DMRD, 120);
      push_g(K_IF,   50, 0); push_r(K_IF,   150);
      push_g(K_DMRD, 20, 0); push_r(K_DMRD, 120);
      push_g(K_DMRD, 20, 0); push_r(K_DMRD, 120);
      push_g(K_IF,   51, 0); push_r(K_IF,   151);
      #1;
      if_req = 1'b1; if_addr = 10'd50;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd20; dm_wdata = '0;
      g = 0; cyc = 0;
      while (g < 6 && cyc < 30) begin
         @(posedge clk1); #1; cyc++;
         if (if_gnt) begin g++; if_addr = if_addr + 1'b1; end
         if (dm_gnt) g++;
         if (g >= 6) begin if_req = 1'b0; dm_req = 1'b0; end
      end
      chk("contention_grants", 32'(g), 6);
      chk("contention_cycles", 32'(cyc), 6);
      repeat (3) @(posedge clk1);
      chk("load_use_overlap_seen", 32'(overlap_cnt > 0), 1);

      // Store: one write command, no read return.
      push_g(K_DMWR, 5, 32'h0000_001E);
      #1;
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd5; dm_wdata = 32'h0000_001E;
      hit = 1'b0; cyc = 0;
      while (!hit && cyc < 20) begin
         @(posedge clk1); #1; cyc++;
         if (dm_gnt) begin
            hit = 1'b1;
            dm_req = 1'b0; dm_we = 1'b0; dm_wdata = '0;
         end
      end
      chk("store_granted", 32'(hit), 1);
      repeat (3) @(posedge clk1);

      // Halt: data served every cycle, fetch held off until release.
      for (int i = 0; i < 10; i++) begin
         push_g(K_DMRD, 3, 0);
         push_r(K_DMRD, 103);
      end
      push_g(K_IF, 60, 0); push_r(K_IF, 160);
      #1;
      halted = 1'b1; if_req = 1'b1; if_addr = 10'd60;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd3;
      dg = 0; ifg = 0; cyc = 0;
      while (dg < 10 && cyc < 30) begin
         @(posedge clk1); #1; cyc++;
         if (if_gnt) ifg++;
         if (dm_gnt) dg++;
         if (dg >= 10) begin dm_req = 1'b0; halted = 1'b0; end
      end
      chk("halt_dm_grants", 32'(dg), 10);
      chk("halt_no_if_gnt", 32'(ifg), 0);
      @(posedge clk1); #1;
      chk("halt_release_if_gnt", 32'(if_gnt), 1);
      if_req = 1'b0;
      repeat (3) @(posedge clk1);

      // Reset asserted during a fetch grant cycle.
      #1;
      if_req = 1'b1; if_addr = 10'd70;
      hit = 1'b0; cyc = 0;
      while (!hit && cyc < 20) begin
         @(posedge clk1); #1; cyc++;
         if (if_gnt) begin hit = 1'b1; rst_n = 1'b0; end
      end
      chk("midread_grant_seen", 32'(hit), 1);
      #1 chk_zero("midread_reset");
      if_req = 1'b0;
      repeat (2) @(posedge clk1);
      @(negedge clk1) rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk1); #1;
         chk("post_reset_no_if_rvalid", 32'(if_rvalid), 0);
      end

      repeat (2) @(posedge clk1);
      chk("grant_queue_drained", 32'(exp_g.size()), 0);
      chk("read_queue_drained",  32'(exp_r.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/mips_mem_arbiter.md
MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

Interface
REQ-001 Parameter: AW, default 10, word-address width of the shared memory.
REQ-002 Parameter: MAX_DM_RUN, default 2, maximum consecutive data grants while a fetch is pending.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port: clk1  input  1  single clock; all state changes on its rising edge.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: halted  input  1  processor HALTED flag; blocks fetch grants.
REQ-007 Port: if_req / if_addr  input  1 / AW  instruction-fetch request and word address.
REQ-008 Port: if_gnt / if_rvalid  output  1 / 1  fetch grant pulse and fetch read-data-valid pulse.
REQ-009 Port: if_rdata  output  32  fetch read data.
REQ-010 Port: dm_req / dm_we / dm_addr / dm_wdata  input  1 / 1 / AW / 32  data-port request (LW: we=0, SW: we=1), address and write data.
REQ-011 Port: dm_gnt / dm_rvalid  output  1 / 1  data grant pulse and load-data-valid pulse.
REQ-012 Port: dm_rdata  output  32  load data.
REQ-013 Port: mem_en / mem_we / mem_addr / mem_wdata  output  1 / 1 / AW / 32  single-port memory command; mem_addr and mem_wdata are registered.
REQ-014 Port: mem_rdata  input  32  memory read data, valid the cycle after a read command (synchronous read).

Function
REQ-015 The block SHALL hold one state register with states IDLE, IF_ACC, DM_RD and DM_WR, naming the access issued in the current cycle.
REQ-016 At each edge the block SHALL arbitrate on the sampled if_req and dm_req and issue at most one memory command in the following cycle.
REQ-017 Priority SHALL be data over fetch, except if_req is granted when dm_run == MAX_DM_RUN and if_req is pending.
REQ-018 dm_run is a saturating counter that SHALL increment on each data grant while if_req is pending and clear on any fetch grant or any cycle with if_req low.
REQ-019 While halted is high, if_req SHALL be ignored: no if_gnt and dm_run held at 0; data requests are still served.
REQ-020 On grant, the block SHALL assert for exactly one cycle: the matching gnt, mem_en=1, mem_we=dm_we for data and 0 for fetch, and mem_addr/mem_wdata = the sampled request fields.
REQ-021 For a read grant in cycle N, the matching rvalid SHALL be high in cycle N+1 only, with rdata = mem_rdata in that cycle.
REQ-022 A write grant SHALL produce no rvalid.
REQ-023 No grant cycle SHALL give IDLE with mem_en=0, both gnt=0 and mem_we=0.
REQ-024 A requester SHALL hold req, addr and wdata stable until it sees gnt.
REQ-025 req still high at the edge ending a gnt cycle SHALL be a new request, so one requester may be granted every cycle.
REQ-026 if_rvalid and dm_rvalid SHALL never be high in the same cycle; if_gnt and dm_gnt SHALL never be high in the same cycle.
REQ-027 Simultaneous rvalid of the previous read and gnt of a new access SHALL be supported, giving full throughput.
REQ-028 if_rdata and dm_rdata SHALL be 0 when their rvalid is low.

Reset
REQ-029 On rst_n low, the block SHALL asynchronously force state=IDLE, dm_run=0, and all outputs to 0.
REQ-030 A read granted in the cycle reset asserts SHALL produce no rvalid after reset release.
REQ-031 The first grant after release SHALL occur no earlier than the second rising edge with rst_n high.

Verification
REQ-032 Fetch only: if_req=1, if_addr=0..8 with back-to-back handshake, mem_rdata=addr+100 -> if_gnt on 9 consecutive cycles, if_rdata=100..108 each one cycle later.
REQ-033 Contention: if_req and dm_req (LW, addr 20) held high continuously, MAX_DM_RUN=2 -> grant order DM, DM, IF, DM, DM, IF...; dm_run never exceeds 2.
REQ-034 Store: dm_req=1, dm_we=1, dm_addr=5, dm_wdata=32'h0000_001E -> one cycle with mem_en=1, mem_we=1, mem_addr=5, mem_wdata=0x1E; no dm_rvalid.
REQ-035 Halt: halted=1 with if_req=1 and dm_req=1 (LW addr 3) -> only dm_gnt; if_gnt stays 0 for 10 cycles; halted=0 -> if_gnt within 1 cycle once dm_req drops.
REQ-036 Reset mid-read: rst_n low during an IF_ACC cycle -> all outputs 0 immediately; no if_rvalid after release.
REQ-037 Load-use: a DM_RD grant, then an IF grant next cycle -> dm_rvalid and if_gnt high together; dm_rdata matches the addressed word; no grant overlap.
